// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multi-cycle controller and the shared
// instruction/data memory. The controller is the master: it raises mem_req,
// selects the address source and qualifies writes; memory answers mem_ready.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic MemWrite;
  logic AdrSrc;

  modport master (output mem_req, output MemWrite, output AdrSrc, input mem_ready);
  modport slave  (input mem_req, input MemWrite, input AdrSrc, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath. Walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath
// selects every cycle; stalls on the shared memory via the req/ready bundle.
// Optional feature macro: MC_PERF_CNT_EN adds cycle_count / instret_count.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic [6:0]         op,
  input  logic               Zero,
  multicycle_controller_if.master mem,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUOp,
  output logic               RegWrite,
  output logic               illegal_op,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]        cycle_count,
  output logic [31:0]        instret_count,
`endif
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECUTER = STATE_W'(6),
    S_EXECUTEI = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_BEQ      = STATE_W'(9),
    S_JAL      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q;
  state_t state_d;
  logic   pc_update;
  logic   branch;
  logic   ir_load;

  // State register; reset forces FETCH immediately, abandoning any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Per-state outputs and next-state selection (Moore, gated by mem_ready/Zero).
  always_comb begin
    state_d       = S_FETCH;
    mem.mem_req   = 1'b0;
    mem.MemWrite  = 1'b0;
    mem.AdrSrc    = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    ALUOp         = 2'b00;
    RegWrite      = 1'b0;
    illegal_op    = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_load       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        if (mem.mem_ready) begin
          ir_load   = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end else begin
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem.mem_req = 1'b1;
        mem.AdrSrc  = 1'b1;
        state_d     = mem.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem.mem_req  = 1'b1;
        mem.MemWrite = 1'b1;
        mem.AdrSrc   = 1'b1;
        state_d      = mem.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;  // unused encodings recover to FETCH
    endcase
    // Reset gates the load enables so FETCH's static outputs can show during
    // reset without loading IR or PC.
    IRWrite = ir_load & rst;
    PCWrite = ((pc_update & rst) | (branch & Zero));
  end

  assign state = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;
  logic        retire;

  // An instruction retires on the edge that returns to FETCH from a final step.
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                  ((state_q == S_MEMWRITE) && mem.mem_ready);

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RV32I datapath. It replaces the single-cycle main decoder's per-instruction decode with a per-cycle state sequence. Each instruction is walked through fetch, decode, execute, memory and writeback steps, and the datapath select/enable lines are driven each cycle. It stalls on a shared instruction/data memory through a req/ready handshake. The existing ALU decoder stays downstream on ALUOp.

## Interface
Parameters:
- STATE_W, 4, width of the state register and the `state` debug output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- op  input  7  opcode field from the instruction register.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- MemWrite  output  1  write strobe; valid only while mem_req=1.
- IRWrite  output  1  load instruction register and OldPC.
- PCWrite  output  1  PC load enable, equal to PCUpdate | (Branch & Zero).
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
- ALUSrcA  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  SrcB select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUOp  output  2  class code for the ALU decoder: 00 = add, 01 = sub/branch, 10 = funct-decoded.
- RegWrite  output  1  register file write enable.
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  output  STATE_W  current state, for debug.

## Operation
States, with each state's non-zero outputs and its next state:
- FETCH (0): mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
  - IRWrite and PCUpdate are asserted only in the cycle where mem_ready=1.
  - Holds while mem_ready=0. Goes to DECODE on mem_ready=1.
- DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch target into ALUOut. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → FETCH, with illegal_op=1.
- MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD (3): mem_req, AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite. Goes to FETCH.
- MEMWRITE (5): mem_req, MemWrite, AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to FETCH.
- EXECUTER (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB (8): ResultSrc=00, RegWrite. Goes to FETCH.
- BEQ (9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
- JAL (10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate. Goes to ALUWB.

Unused encodings 11–15 go to FETCH on the next edge, with all outputs at their defaults.

All outputs are combinational from state, op, Zero and mem_ready (Moore, plus mem_ready and Zero gating). Any output not listed for a state is 0.

## Timing
- Reset (rst=0, any time): state=FETCH immediately, without waiting for a clock edge. Any in-flight access is abandoned.
  - No write is lost silently: MemWrite is only meaningful with mem_ready.
- While rst=0, every output is 0 except FETCH's static outputs (mem_req=1, ALUSrcB=10, ResultSrc=10).
  - IRWrite and PCWrite stay 0 because PCUpdate is gated by rst.
- Cycle counts with zero-wait memory:
  - R-type and I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
  - Each memory wait cycle adds 1.
- Handshake:
  - While mem_req=1, AdrSrc and MemWrite hold stable until the mem_ready=1 cycle.
  - The transfer completes on the rising edge where mem_req & mem_ready.
  - mem_ready while mem_req=0 is ignored.
- illegal_op is high for exactly the DECODE cycle.

## Configuration
- MC_PERF_CNT_EN defined: adds two 32-bit outputs, cycle_count and instret_count.
  - cycle_count increments every clock while rst=1.
  - instret_count increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. The illegal-op exit does not count.
  - Both counters wrap from 0xFFFFFFFF to 0. Both clear to 0 on reset.
- MC_PERF_CNT_EN undefined: the counters and ports are absent and behaviour is otherwise identical.

## Test plan
- Reset mid-MEMREAD with mem_ready=0: assert rst=0 → state=0 asynchronously. After release, the first mem_ready gives IRWrite=1 and PCWrite=1.
- Zero-wait add, op=0110011: states 0,1,6,8 → RegWrite=1 only in cycle 4, ALUOp=10 in cycle 3, back in FETCH in cycle 5.
- lw, op=0000011, with mem_ready low for 2 extra cycles in MEMREAD: states 0,1,2,3,3,3,4 → AdrSrc=1 through all three MEMREAD cycles, ResultSrc=01 in MEMWB.
- beq, op=1100011:
  - Zero=1 → PCWrite=1 in BEQ.
  - Zero=0 → PCWrite=0.
  - Both cases return to FETCH after 3 cycles.
- jal, op=1101111: states 0,1,10,8 → PCWrite=1 in JAL, RegWrite=1 in ALUWB.
- op=0000000 → illegal_op=1 for one DECODE cycle, next state FETCH. With MC_PERF_CNT_EN, instret_count is unchanged and cycle_count advances by 2.
